// File: rtl/alu_issue_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality helper for the ALU command issuer.
package alu_issue_pkg;

   localparam logic [3:0] ADD    = 4'd0;
   localparam logic [3:0] SUB    = 4'd1;
   localparam logic [3:0] AND    = 4'd2;
   localparam logic [3:0] OR     = 4'd3;
   localparam logic [3:0] MIN    = 4'd4;
   localparam logic [3:0] OP_MAX = 4'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_MAX);
   endfunction

endpackage

// File: rtl/alu_issue_latency_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module alu_issue_latency_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues commands to an ALU, waits ALU_LATENCY cycles, returns result/carry and keeps an accumulator.
// Optional ALU_ISSUE_STATS_EN adds saturating op/carry/error counters.
module alu_cmd_issuer
   import alu_issue_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter int ALU_LATENCY = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   input  logic             cmd_acc_clr,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [4:0]       alu_shift_value,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [WIDTH-1:0] acc_value
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]      stat_ops,
   output logic [31:0]      stat_carries,
   output logic [15:0]      stat_errs
`endif
);

   localparam logic [2:0] LAT = ALU_LATENCY[2:0];

   state_t           state_q, state_d;
   logic [3:0]       alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0] alu_input1_q, alu_input1_d;
   logic [WIDTH-1:0] alu_input2_q, alu_input2_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_err_q, rsp_err_d;
   logic             cnt_load;
   logic             cnt_done;

   alu_issue_latency_cnt #(.CNT_W(3)) u_lat_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (LAT),
      .done     (cnt_done)
   );

   always_comb begin
      state_d      = state_q;
      alu_opcode_d = alu_opcode_q;
      alu_input1_d = alu_input1_q;
      alu_input2_d = alu_input2_q;
      acc_d        = acc_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;
      cnt_load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_acc_clr) begin
                  acc_d = '0;
               end
               if (is_legal_op(cmd_opcode)) begin
                  alu_opcode_d = cmd_opcode;
                  alu_input1_d = cmd_use_acc ? (cmd_acc_clr ? '0 : acc_q) : cmd_a;
                  alu_input2_d = cmd_b;
                  cnt_load     = 1'b1;
                  state_d      = WAIT;
               end else begin
                  // Illegal ops never reach the ALU; answer immediately with an error.
                  rsp_valid_d  = 1'b1;
                  rsp_err_d    = 1'b1;
                  rsp_result_d = '0;
                  rsp_carry_d  = 1'b0;
                  state_d      = RESPOND;
               end
            end
         end
         WAIT: begin
            if (cnt_done) begin
               rsp_valid_d  = 1'b1;
               rsp_result_d = alu_result;
               rsp_carry_d  = alu_carry;
               rsp_err_d    = 1'b0;
               acc_d        = alu_result;
               state_d      = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_opcode_q <= '0;
         alu_input1_q <= '0;
         alu_input2_q <= '0;
         acc_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_opcode_q <= alu_opcode_d;
         alu_input1_q <= alu_input1_d;
         alu_input2_q <= alu_input2_d;
         acc_q        <= acc_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready       = (state_q == IDLE);
   assign alu_opcode      = alu_opcode_q;
   assign alu_input1      = alu_input1_q;
   assign alu_input2      = alu_input2_q;
   assign alu_shift_value = 5'd0;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_result      = rsp_result_q;
   assign rsp_carry       = rsp_carry_q;
   assign rsp_err         = rsp_err_q;
   assign acc_value       = acc_q;

`ifdef ALU_ISSUE_STATS_EN
   logic        rsp_hs;
   logic [31:0] stat_ops_q, stat_carries_q;
   logic [15:0] stat_errs_q;

   assign rsp_hs = (state_q == RESPOND) && rsp_ready;

   // Counters saturate rather than wrap so a long soak never reads back small.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q     <= '0;
         stat_carries_q <= '0;
         stat_errs_q    <= '0;
      end else if (rsp_hs) begin
         if (!rsp_err_q && (stat_ops_q != '1)) begin
            stat_ops_q <= stat_ops_q + 1'b1;
         end
         if (rsp_carry_q && (stat_carries_q != '1)) begin
            stat_carries_q <= stat_carries_q + 1'b1;
         end
         if (rsp_err_q && (stat_errs_q != '1)) begin
            stat_errs_q <= stat_errs_q + 1'b1;
         end
      end
   end

   assign stat_ops     = stat_ops_q;
   assign stat_carries = stat_carries_q;
   assign stat_errs    = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: one instance on a combinational ALU, one on a 3-stage piped ALU.
module tb_alu_cmd_issuer;
   import alu_issue_pkg::*;

   typedef struct packed {
      logic [63:0] res;
      logic        c;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  op;
   logic [63:0] a, b;
   logic        use_acc, acc_clr;
   logic        v0, v3, r0, r3;

   logic        rdy0, rv0, rc0, re0, car0;
   logic [3:0]  aop0;
   logic [4:0]  sh0;
   logic [63:0] ai1_0, ai2_0, rr0, acc0, res0;

   logic        rdy3, rv3, rc3, re3, car3;
   logic [3:0]  aop3;
   logic [4:0]  sh3;
   logic [63:0] ai1_3, ai2_3, rr3, acc3, res3;

   logic [64:0] p3_0 = '0, p3_1 = '0, p3_2 = '0;

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] so0, sc0, so3, sc3;
   logic [15:0] se0, se3;
`endif

   exp_t sb0[$];
   exp_t sb3[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [64:0] alu_m(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [64:0] s;
      case (o)
         ADD:     s = {1'b0, x} + {1'b0, y};
         SUB:     s = {(x < y), x - y};
         AND:     s = {1'b0, x & y};
         OR:      s = {1'b0, x | y};
         MIN:     s = {1'b0, (x < y) ? x : y};
         default: s = '0;
      endcase
      return s;
   endfunction

   assign {car0, res0} = alu_m(aop0, ai1_0, ai2_0);

   always @(posedge clk) begin
      p3_0 <= alu_m(aop3, ai1_3, ai2_3);
      p3_1 <= p3_0;
      p3_2 <= p3_1;
   end
   assign {car3, res3} = p3_2;

   alu_cmd_issuer #(.WIDTH(64), .ALU_LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_opcode(op),
      .cmd_a(a), .cmd_b(b), .cmd_use_acc(use_acc), .cmd_acc_clr(acc_clr),
      .alu_opcode(aop0), .alu_input1(ai1_0), .alu_input2(ai2_0), .alu_shift_value(sh0),
      .alu_result(res0), .alu_carry(car0), .rsp_valid(rv0), .rsp_ready(r0),
      .rsp_result(rr0), .rsp_carry(rc0), .rsp_err(re0), .acc_value(acc0)
`ifdef ALU_ISSUE_STATS_EN
      , .stat_ops(so0), .stat_carries(sc0), .stat_errs(se0)
`endif
   );

   alu_cmd_issuer #(.WIDTH(64), .ALU_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_opcode(op),
      .cmd_a(a), .cmd_b(b), .cmd_use_acc(use_acc), .cmd_acc_clr(acc_clr),
      .alu_opcode(aop3), .alu_input1(ai1_3), .alu_input2(ai2_3), .alu_shift_value(sh3),
      .alu_result(res3), .alu_carry(car3), .rsp_valid(rv3), .rsp_ready(r3),
      .rsp_result(rr3), .rsp_carry(rc3), .rsp_err(re3), .acc_value(acc3)
`ifdef ALU_ISSUE_STATS_EN
      , .stat_ops(so3), .stat_carries(sc3), .stat_errs(se3)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one command; returns at the negedge following the accepting edge.
   task automatic issue(input int d, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic ua, input logic ac);
      op = o; a = x; b = y; use_acc = ua; acc_clr = ac;
      if (d == 0) begin
         v0 = 1'b1;
         check("rdy0_pre", {63'd0, rdy0}, 64'd1);
      end else begin
         v3 = 1'b1;
         check("rdy3_pre", {63'd0, rdy3}, 64'd1);
      end
      @(negedge clk);
      v0 = 1'b0;
      v3 = 1'b0;
      $display("issue dut%0d op=%0d a=%0h b=%0h use_acc=%0b acc_clr=%0b", d, o, x, y, ua, ac);
   endtask

   // Wait for a dut0 response, compare it with the scoreboard head, optionally stall, then handshake.
   task automatic rsp0(input int hold);
      exp_t e;
      int   t;
      t = 0;
      while (!rv0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("rsp0_timeout", {63'd0, rv0}, 64'd1);
      if (sb0.size() == 0) begin
         check("sb0_empty", 64'(sb0.size()), 64'd1);
      end else begin
         e = sb0.pop_front();
         check("rsp0_result", rr0, e.res);
         check("rsp0_carry", {63'd0, rc0}, {63'd0, e.c});
         check("rsp0_err", {63'd0, re0}, {63'd0, e.e});
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_result", rr0, e.res);
            check("bp_carry", {63'd0, rc0}, {63'd0, e.c});
            check("bp_rdy", {63'd0, rdy0}, 64'd0);
         end
         $display("rsp dut0 result=%0h carry=%0b err=%0b", rr0, rc0, re0);
      end
      r0 = 1'b1;
      @(negedge clk);
      r0 = 1'b0;
      check("hs_rv0", {63'd0, rv0}, 64'd0);
      check("hs_rdy0", {63'd0, rdy0}, 64'd1);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0; r0 = 1'b0; r3 = 1'b0;
      op = '0; a = '0; b = '0; use_acc = 1'b0; acc_clr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdy", {63'd0, rdy0}, 64'd1);
      check("rst_rv", {63'd0, rv0}, 64'd0);
      check("rst_rr", rr0, 64'd0);
      check("rst_rc_re", {62'd0, rc0, re0}, 64'd0);
      check("rst_aop", {60'd0, aop0}, 64'd0);
      check("rst_ai1", ai1_0, 64'd0);
      check("rst_ai2", ai2_0, 64'd0);
      check("rst_acc", acc0, 64'd0);
      check("rst_shift", {59'd0, sh0}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD with carry out, combinational ALU: valid exactly one cycle after accept.
      sb0.push_back('{res: 64'd0, c: 1'b1, e: 1'b0});
      issue(0, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      check("add_lat_wait", {63'd0, rv0}, 64'd0);
      check("add_busy", {63'd0, rdy0}, 64'd0);
      @(negedge clk);
      check("add_lat_valid", {63'd0, rv0}, 64'd1);
      rsp0(0);
      check("add_acc", acc0, 64'd0);

      // Chain through the accumulator.
      sb0.push_back('{res: 64'd7, c: 1'b0, e: 1'b0});
      issue(0, SUB, 64'd10, 64'd3, 1'b0, 1'b0);
      rsp0(0);
      check("chain_acc7", acc0, 64'd7);
      sb0.push_back('{res: 64'd12, c: 1'b0, e: 1'b0});
      issue(0, ADD, 64'd100, 64'd5, 1'b1, 1'b0);
      check("chain_in1", ai1_0, 64'd7);
      rsp0(0);
      sb0.push_back('{res: 64'd4, c: 1'b0, e: 1'b0});
      issue(0, MIN, 64'd100, 64'd4, 1'b1, 1'b0);
      rsp0(0);
      check("chain_acc4", acc0, 64'd4);

      // Illegal opcode: error response, ALU drive and accumulator untouched.
      sb0.push_back('{res: 64'd0, c: 1'b0, e: 1'b1});
      issue(0, 4'd9, 64'd5, 64'd6, 1'b0, 1'b0);
      check("ill_aop", {60'd0, aop0}, {60'd0, MIN});
      check("ill_ai1", ai1_0, 64'd12);
      check("ill_ai2", ai2_0, 64'd4);
      rsp0(0);
      check("ill_acc", acc0, 64'd4);

      // Backpressure with a second command waiting; it must be taken only after the handshake.
      sb0.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b1, e: 1'b0});
      issue(0, SUB, 64'd3, 64'd5, 1'b0, 1'b0);
      op = ADD; a = 64'd1; b = 64'd1; use_acc = 1'b0; acc_clr = 1'b0;
      v0 = 1'b1;
      sb0.push_back('{res: 64'd2, c: 1'b0, e: 1'b0});
      @(negedge clk);
      rsp0(5);
      @(negedge clk);
      v0 = 1'b0;
      check("bp_next_wait", {63'd0, rv0}, 64'd0);
      rsp0(0);

      // Accumulator clear combined with use_acc feeds zero to the ALU.
      sb0.push_back('{res: 64'd9, c: 1'b0, e: 1'b0});
      issue(0, ADD, 64'd50, 64'd9, 1'b1, 1'b1);
      check("clr_in1", ai1_0, 64'd0);
      rsp0(0);

`ifdef ALU_ISSUE_STATS_EN
      check("stat_ops", {32'd0, so0}, 64'd7);
      check("stat_carries", {32'd0, sc0}, 64'd2);
      check("stat_errs", {48'd0, se0}, 64'd1);
`endif

      // Three-cycle ALU: valid exactly four cycles after accept.
      sb3.push_back('{res: 64'hFF, c: 1'b0, e: 1'b0});
      issue(3, OR, 64'hF0, 64'h0F, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("lat3_wait", {63'd0, rv3}, 64'd0);
      end
      @(negedge clk);
      check("lat3_valid", {63'd0, rv3}, 64'd1);
      e = sb3.pop_front();
      check("lat3_result", rr3, e.res);
      check("lat3_carry", {63'd0, rc3}, {63'd0, e.c});
      $display("rsp dut3 result=%0h carry=%0b err=%0b", rr3, rc3, re3);
      r3 = 1'b1;
      @(negedge clk);
      r3 = 1'b0;
      check("lat3_acc", acc3, 64'hFF);

      // Reset while waiting aborts the op without a response.
      issue(3, ADD, 64'd5, 64'd6, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_acc", acc3, 64'd0);
      check("abort_rv", {63'd0, rv3}, 64'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort_no_rsp", {63'd0, rv3}, 64'd0);
      end
      check("abort_rdy", {63'd0, rdy3}, 64'd1);
      check("abort_acc_after", acc3, 64'd0);
`ifdef ALU_ISSUE_STATS_EN
      check("abort_stats", {so3, sc3}, 64'd0);
      check("abort_stat_errs", {48'd0, se3}, 64'd0);
      check("abort_stats0", {so0, sc0}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
